// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
//  config_pkg
//  Core configuration type. Carries the PMA region rule tables that are
//  consumed by pma_check_pipe.
//  Revision: 1.0
// ============================================================================
package config_pkg;

    localparam int unsigned MAX_PMA_RULES = 16;

    typedef struct packed {
        int unsigned                          NrCachedRegionRules;
        logic [MAX_PMA_RULES-1:0][63:0]       CachedRegionAddrBase;
        logic [MAX_PMA_RULES-1:0][63:0]       CachedRegionLength;
        int unsigned                          NrExecuteRegionRules;
        logic [MAX_PMA_RULES-1:0][63:0]       ExecuteRegionAddrBase;
        logic [MAX_PMA_RULES-1:0][63:0]       ExecuteRegionLength;
        int unsigned                          NrNonIdempotentRules;
        logic [MAX_PMA_RULES-1:0][63:0]       NonIdempotentAddrBase;
        logic [MAX_PMA_RULES-1:0][63:0]       NonIdempotentLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage
`default_nettype wire

// File: rtl/pma_check_pipe.sv
`default_nettype none
// ============================================================================
//  pma_check_pipe
//  Two-stage pipelined PMA lookup: classifies physical addresses as cacheable,
//  executable and non-idempotent. Optional response statistics counters are
//  enabled by defining PMA_CHECK_STATS_EN.
//  Revision: 1.0
// ============================================================================
module pma_check_pipe #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           IdWidth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [63:0]        req_addr_i,
    input  logic [IdWidth-1:0] req_id_i,
    input  logic               req_fetch_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [63:0]        rsp_addr_o,
    output logic [IdWidth-1:0] rsp_id_o,
    output logic               rsp_cacheable_o,
    output logic               rsp_executable_o,
    output logic               rsp_nonidempotent_o,
    output logic               rsp_exec_fault_o,
    output logic [31:0]        stat_exec_fault_o,
    output logic [31:0]        stat_uncached_o
);

    localparam int MAX_RULES = int'(config_pkg::MAX_PMA_RULES);
    localparam int N_CACHED  = (CVA6Cfg.NrCachedRegionRules  > 16) ? MAX_RULES : int'(CVA6Cfg.NrCachedRegionRules);
    localparam int N_EXEC    = (CVA6Cfg.NrExecuteRegionRules > 16) ? MAX_RULES : int'(CVA6Cfg.NrExecuteRegionRules);
    localparam int N_NONIDEM = (CVA6Cfg.NrNonIdempotentRules > 16) ? MAX_RULES : int'(CVA6Cfg.NrNonIdempotentRules);
    localparam bit EXEC_ALL  = (N_EXEC == 0);

    // ------------------------------------------------------------------
    // Per-rule compare against the incoming address
    // ------------------------------------------------------------------
    logic [MAX_RULES-1:0] cached_ge,  cached_lt;
    logic [MAX_RULES-1:0] exec_ge,    exec_lt;
    logic [MAX_RULES-1:0] nonidem_ge, nonidem_lt;

    // Upper bound is formed in 65 bits so a region ending at 2^64 cannot wrap.
    for (genvar k = 0; k < MAX_RULES; k++) begin : g_rule
        if (k < N_CACHED) begin : g_cached
            assign cached_ge[k] = req_addr_i >= CVA6Cfg.CachedRegionAddrBase[k];
            assign cached_lt[k] = {1'b0, req_addr_i} <
                                  ({1'b0, CVA6Cfg.CachedRegionAddrBase[k]} + {1'b0, CVA6Cfg.CachedRegionLength[k]});
        end else begin : g_cached_off
            assign cached_ge[k] = 1'b0;
            assign cached_lt[k] = 1'b0;
        end

        if (k < N_EXEC) begin : g_exec
            assign exec_ge[k] = req_addr_i >= CVA6Cfg.ExecuteRegionAddrBase[k];
            assign exec_lt[k] = {1'b0, req_addr_i} <
                                ({1'b0, CVA6Cfg.ExecuteRegionAddrBase[k]} + {1'b0, CVA6Cfg.ExecuteRegionLength[k]});
        end else begin : g_exec_off
            assign exec_ge[k] = 1'b0;
            assign exec_lt[k] = 1'b0;
        end

        if (k < N_NONIDEM) begin : g_nonidem
            assign nonidem_ge[k] = req_addr_i >= CVA6Cfg.NonIdempotentAddrBase[k];
            assign nonidem_lt[k] = {1'b0, req_addr_i} <
                                   ({1'b0, CVA6Cfg.NonIdempotentAddrBase[k]} + {1'b0, CVA6Cfg.NonIdempotentLength[k]});
        end else begin : g_nonidem_off
            assign nonidem_ge[k] = 1'b0;
            assign nonidem_lt[k] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic s1_ready;
    logic s2_ready;
    logic accept;
    logic s2_load;

    assign s2_ready    = ~s2_valid_q | rsp_ready_i;
    assign s1_ready    = ~s1_valid_q | s2_ready;
    assign req_ready_o = s1_ready & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;
    assign s2_load     = s1_valid_q & s2_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else if (flush_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid_q <= accept;
            end
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 datapath
    // ------------------------------------------------------------------
    logic [63:0]          s1_addr_q;
    logic [IdWidth-1:0]   s1_id_q;
    logic                 s1_fetch_q;
    logic [MAX_RULES-1:0] s1_cached_ge_q,  s1_cached_lt_q;
    logic [MAX_RULES-1:0] s1_exec_ge_q,    s1_exec_lt_q;
    logic [MAX_RULES-1:0] s1_nonidem_ge_q, s1_nonidem_lt_q;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            s1_addr_q       <= req_addr_i;
            s1_id_q         <= req_id_i;
            s1_fetch_q      <= req_fetch_i;
            s1_cached_ge_q  <= cached_ge;
            s1_cached_lt_q  <= cached_lt;
            s1_exec_ge_q    <= exec_ge;
            s1_exec_lt_q    <= exec_lt;
            s1_nonidem_ge_q <= nonidem_ge;
            s1_nonidem_lt_q <= nonidem_lt;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: reduce hits to class flags and register the response
    // ------------------------------------------------------------------
    logic cacheable_d;
    logic executable_d;
    logic nonidem_d;
    logic fault_d;

    // With no execute rules configured, every address is executable.
    assign cacheable_d  = |(s1_cached_ge_q & s1_cached_lt_q);
    assign executable_d = EXEC_ALL | (|(s1_exec_ge_q & s1_exec_lt_q));
    assign nonidem_d    = |(s1_nonidem_ge_q & s1_nonidem_lt_q);
    assign fault_d      = s1_fetch_q & ~executable_d;

    logic [63:0]        rsp_addr_q;
    logic [IdWidth-1:0] rsp_id_q;
    logic               rsp_cacheable_q;
    logic               rsp_executable_q;
    logic               rsp_nonidem_q;
    logic               rsp_fault_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_addr_q       <= '0;
            rsp_id_q         <= '0;
            rsp_cacheable_q  <= 1'b0;
            rsp_executable_q <= 1'b0;
            rsp_nonidem_q    <= 1'b0;
            rsp_fault_q      <= 1'b0;
        end else if (s2_load) begin
            rsp_addr_q       <= s1_addr_q;
            rsp_id_q         <= s1_id_q;
            rsp_cacheable_q  <= cacheable_d;
            rsp_executable_q <= executable_d;
            rsp_nonidem_q    <= nonidem_d;
            rsp_fault_q      <= fault_d;
        end
    end

    assign rsp_valid_o         = s2_valid_q;
    assign rsp_addr_o          = rsp_addr_q;
    assign rsp_id_o            = rsp_id_q;
    assign rsp_cacheable_o     = rsp_cacheable_q;
    assign rsp_executable_o    = rsp_executable_q;
    assign rsp_nonidempotent_o = rsp_nonidem_q;
    assign rsp_exec_fault_o    = rsp_fault_q;

    // ------------------------------------------------------------------
    // Optional response statistics
    // ------------------------------------------------------------------
`ifdef PMA_CHECK_STATS_EN
    logic [31:0] stat_exec_fault_q;
    logic [31:0] stat_uncached_q;
    logic        rsp_fire;

    assign rsp_fire = s2_valid_q & rsp_ready_i;

    // Counters saturate and survive flush; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_exec_fault_q <= '0;
            stat_uncached_q   <= '0;
        end else if (rsp_fire) begin
            if (rsp_fault_q && (stat_exec_fault_q != 32'hFFFF_FFFF)) begin
                stat_exec_fault_q <= stat_exec_fault_q + 32'd1;
            end
            if (!rsp_cacheable_q && (stat_uncached_q != 32'hFFFF_FFFF)) begin
                stat_uncached_q <= stat_uncached_q + 32'd1;
            end
        end
    end

    assign stat_exec_fault_o = stat_exec_fault_q;
    assign stat_uncached_o   = stat_uncached_q;
`else
    assign stat_exec_fault_o = '0;
    assign stat_uncached_o   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pma_check_pipe.sv
`default_nettype none
// ============================================================================
//  tb_pma_check_pipe
//  Scoreboard bench: two DUT instances (full rule set / zero execute rules)
//  share one stimulus stream and are checked against a region-rule model.
//  Revision: 1.0
// ============================================================================
module tb_pma_check_pipe;

    localparam int IDW = 4;
`ifdef PMA_CHECK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [63:0]    addr;
        logic [IDW-1:0] id;
        logic [3:0]     flags;  // {cacheable, executable, nonidempotent, exec_fault}
    } exp_t;

    function automatic config_pkg::cva6_cfg_t mk_cfg(input bit variant);
        config_pkg::cva6_cfg_t c;
        c = '0;
        c.CachedRegionAddrBase[0] = 64'h8000_0000;
        c.CachedRegionLength[0]   = 64'h4000_0000;
        if (!variant) begin
            c.NrCachedRegionRules      = 2;
            c.CachedRegionAddrBase[1]  = 64'hFFFF_FFFF_FFFF_F000;
            c.CachedRegionLength[1]    = 64'h1000;
            c.NrNonIdempotentRules     = 1;
            c.NonIdempotentAddrBase[0] = 64'h0;
            c.NonIdempotentLength[0]   = 64'h8000_0000;
            c.NrExecuteRegionRules     = 2;
            c.ExecuteRegionAddrBase[0] = 64'h1_0000;
            c.ExecuteRegionLength[0]   = 64'h1_0000;
            c.ExecuteRegionAddrBase[1] = 64'h8000_0000;
            c.ExecuteRegionLength[1]   = 64'h4000_0000;
        end else begin
            // Populated slots beyond the rule counts must be ignored.
            c.NrCachedRegionRules      = 1;
            c.CachedRegionAddrBase[1]  = 64'h0;
            c.CachedRegionLength[1]    = 64'h1_0000_0000;
            c.NrNonIdempotentRules     = 0;
            c.NonIdempotentAddrBase[0] = 64'h0;
            c.NonIdempotentLength[0]   = 64'hFFFF_FFFF_FFFF_FFFF;
            c.NrExecuteRegionRules     = 0;
            c.ExecuteRegionAddrBase[0] = 64'h0;
            c.ExecuteRegionLength[0]   = 64'h1000;
        end
        return c;
    endfunction

    localparam config_pkg::cva6_cfg_t CFG_A = mk_cfg(1'b0);
    localparam config_pkg::cva6_cfg_t CFG_B = mk_cfg(1'b1);

    // Reference model: an address belongs to a class if base <= a < base+len
    // (unbounded arithmetic) for any of the first n rules.
    function automatic bit in_regions(input logic [63:0] a, input int unsigned n,
                                      input logic [15:0][63:0] base, input logic [15:0][63:0] len);
        logic [64:0] lo, hi, av;
        av = {1'b0, a};
        for (int k = 0; k < 16; k++) begin
            if (k < int'(n)) begin
                lo = {1'b0, base[k]};
                hi = lo + {1'b0, len[k]};
                if (av >= lo && av < hi) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic exp_t model(input config_pkg::cva6_cfg_t c, input logic [63:0] a,
                                   input logic [IDW-1:0] id, input logic fetch);
        exp_t e;
        bit ca, ex, ni;
        ca = in_regions(a, c.NrCachedRegionRules, c.CachedRegionAddrBase, c.CachedRegionLength);
        ni = in_regions(a, c.NrNonIdempotentRules, c.NonIdempotentAddrBase, c.NonIdempotentLength);
        ex = (c.NrExecuteRegionRules == 0) ? 1'b1
             : in_regions(a, c.NrExecuteRegionRules, c.ExecuteRegionAddrBase, c.ExecuteRegionLength);
        e.addr  = a;
        e.id    = id;
        e.flags = {ca, ex, ni, fetch & ~ex};
        return e;
    endfunction

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            flush;
    logic            req_valid;
    logic [63:0]     req_addr;
    logic [IDW-1:0]  req_id;
    logic            req_fetch;
    logic            rsp_ready;

    logic            req_ready  [2];
    logic            rsp_valid  [2];
    logic [63:0]     rsp_addr   [2];
    logic [IDW-1:0]  rsp_id     [2];
    logic            rsp_c      [2];
    logic            rsp_x      [2];
    logic            rsp_n      [2];
    logic            rsp_f      [2];
    logic [31:0]     stat_f     [2];
    logic [31:0]     stat_u     [2];

    always #5 clk = ~clk;

    pma_check_pipe #(.CVA6Cfg(CFG_A), .IdWidth(IDW)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .req_addr_i(req_addr),
        .req_id_i(req_id), .req_fetch_i(req_fetch),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_addr_o(rsp_addr[0]),
        .rsp_id_o(rsp_id[0]), .rsp_cacheable_o(rsp_c[0]), .rsp_executable_o(rsp_x[0]),
        .rsp_nonidempotent_o(rsp_n[0]), .rsp_exec_fault_o(rsp_f[0]),
        .stat_exec_fault_o(stat_f[0]), .stat_uncached_o(stat_u[0])
    );

    pma_check_pipe #(.CVA6Cfg(CFG_B), .IdWidth(IDW)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .req_addr_i(req_addr),
        .req_id_i(req_id), .req_fetch_i(req_fetch),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_addr_o(rsp_addr[1]),
        .rsp_id_o(rsp_id[1]), .rsp_cacheable_o(rsp_c[1]), .rsp_executable_o(rsp_x[1]),
        .rsp_nonidempotent_o(rsp_n[1]), .rsp_exec_fault_o(rsp_f[1]),
        .stat_exec_fault_o(stat_f[1]), .stat_uncached_o(stat_u[1])
    );

    int          vectors    = 0;
    int          miscompares = 0;
    exp_t        q [2][$];
    logic [31:0] m_f [2];
    logic [31:0] m_u [2];
    bit          rand_rdy = 1'b0;
    logic [IDW-1:0] next_id = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_ni) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("stat_exec_fault[%0d]", d), 64'(stat_f[d]), 64'(m_f[d]));
                chk($sformatf("stat_uncached[%0d]", d), 64'(stat_u[d]), 64'(m_u[d]));
                if (rsp_valid[d]) begin
                    if (q[d].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rsp_spurious[%0d]: actual valid id %0h required no response", d, rsp_id[d]);
                    end else begin
                        exp_t e;
                        e = q[d][0];
                        chk($sformatf("rsp_addr[%0d]", d), rsp_addr[d], e.addr);
                        chk($sformatf("rsp_id[%0d]", d), 64'(rsp_id[d]), 64'(e.id));
                        chk($sformatf("rsp_flags_cxnf[%0d]", d),
                            64'({rsp_c[d], rsp_x[d], rsp_n[d], rsp_f[d]}), 64'(e.flags));
                        if (rsp_ready) begin
                            void'(q[d].pop_front());
                            if (STATS && e.flags[0] && m_f[d] != 32'hFFFF_FFFF) m_f[d] = m_f[d] + 1;
                            if (STATS && !e.flags[3] && m_u[d] != 32'hFFFF_FFFF) m_u[d] = m_u[d] + 1;
                        end
                    end
                end
                if (flush) q[d].delete();
            end
        end
    end

    // Background consumer backpressure
    always begin
        @(posedge clk);
        #2;
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [63:0] a, input logic fetch);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_id    = next_id;
        req_fetch = fetch;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                q[0].push_back(model(CFG_A, a, next_id, fetch));
                q[1].push_back(model(CFG_B, a, next_id, fetch));
                done = 1'b1;
            end
            tick();
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: actual no accept required accept of addr %0h", a);
        end
        req_valid = 1'b0;
        next_id   = next_id + 1'b1;
    endtask

    task automatic drain();
        rand_rdy = 1'b0;
        tick();
        rsp_ready = 1'b1;
        repeat (4) tick();
    endtask

    function automatic logic [63:0] pick_addr();
        logic [63:0] corners [8];
        logic [63:0] off;
        corners = '{64'h0, 64'h1_0000, 64'h2_0000, 64'h8000_0000, 64'hC000_0000,
                    64'hFFFF_FFFF_FFFF_F000, 64'h0, 64'h1000_0000};
        if ($urandom_range(0, 3) == 0) return {$urandom, $urandom};
        off = 64'($urandom_range(0, 2)) - 64'd1;
        return corners[$urandom_range(0, 7)] + off;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_id = '0;
        req_fetch = 1'b0; rsp_ready = 1'b1;
        for (int d = 0; d < 2; d++) begin m_f[d] = '0; m_u[d] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_rsp_valid", 64'(rsp_valid[d]), 64'd0);
            chk("reset_rsp_addr", rsp_addr[d], 64'd0);
            chk("reset_rsp_flags", 64'({rsp_c[d], rsp_x[d], rsp_n[d], rsp_f[d], rsp_id[d]}), 64'd0);
            chk("reset_stat", 64'({stat_f[d], stat_u[d]}), 64'd0);
        end
        tick();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready[0]), 64'd1);
        tick();

        // Latency and basic classification
        send(64'h8000_1000, 1'b1);
        chk("latency_1cyc_valid", 64'(rsp_valid[0]), 64'd0);
        tick();
        chk("latency_2cyc_valid", 64'(rsp_valid[0]), 64'd1);
        send(64'h1000_0000, 1'b1);
        drain();
        chk("stat_fault_a_after_2", 64'(stat_f[0]), STATS ? 64'd1 : 64'd0);
        chk("stat_uncached_a_after_2", 64'(stat_u[0]), STATS ? 64'd1 : 64'd0);
        chk("stat_uncached_b_after_2", 64'(stat_u[1]), STATS ? 64'd1 : 64'd0);

        // Region boundaries, back to back
        send(64'hBFFF_FFFF, 1'b0);           send(64'hC000_0000, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0); send(64'hFFFF_FFFF_FFFF_F000, 1'b1);
        send(64'hFFFF_FFFF_FFFF_EFFF, 1'b0); send(64'h1_0000, 1'b1);
        send(64'h1_FFFF, 1'b1);              send(64'h2_0000, 1'b1);
        send(64'h7FFF_FFFF, 1'b0);           send(64'h8000_0000, 1'b1);
        drain();

        // Backpressure: consumer stalled for 5 cycles
        rsp_ready = 1'b0;
        send(64'h8000_2000, 1'b0);
        send(64'h0000_4000, 1'b1);
        chk("full_ready_low", 64'(req_ready[0]), 64'd0);
        repeat (3) begin
            tick();
            chk("stall_ready_low", 64'(req_ready[0]), 64'd0);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(64'h8000_0000 + 64'(i) * 64'h1000_0000, i[0]);
        drain();

        // Flush with both stages full and a request pending
        rsp_ready = 1'b0;
        send(64'h8000_3000, 1'b1);
        send(64'h0001_8000, 1'b1);
        flush = 1'b1; req_valid = 1'b1; req_addr = 64'h1234; req_id = 4'hF; req_fetch = 1'b1;
        chk("flush_ready_low", 64'(req_ready[0]), 64'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_clears_valid_a", 64'(rsp_valid[0]), 64'd0);
        chk("flush_clears_valid_b", 64'(rsp_valid[1]), 64'd0);
        rsp_ready = 1'b1;
        send(64'hA000_0000, 1'b1);
        drain();

`ifdef PMA_CHECK_STATS_EN
        // Saturation from a preloaded value
        force dut_a.stat_uncached_q   = 32'hFFFF_FFFE;
        force dut_a.stat_exec_fault_q = 32'hFFFF_FFFE;
        m_u[0] = 32'hFFFF_FFFE;
        m_f[0] = 32'hFFFF_FFFE;
        tick();
        release dut_a.stat_uncached_q;
        release dut_a.stat_exec_fault_q;
        tick();
        for (int i = 0; i < 3; i++) send(64'h1000_0000, 1'b1);
        drain();
        chk("stat_uncached_saturated", 64'(stat_u[0]), 64'hFFFF_FFFF);
        chk("stat_fault_saturated", 64'(stat_f[0]), 64'hFFFF_FFFF);
`endif

        // Reset in mid-operation
        rsp_ready = 1'b0;
        send(64'h8000_4000, 1'b0);
        send(64'h8000_5000, 1'b0);
        rst_ni = 1'b0;
        for (int d = 0; d < 2; d++) begin q[d].delete(); m_f[d] = '0; m_u[d] = '0; end
        @(negedge clk);
        chk("midreset_valid_a", 64'(rsp_valid[0]), 64'd0);
        chk("midreset_valid_b", 64'(rsp_valid[1]), 64'd0);
        chk("midreset_stats", 64'({stat_f[0], stat_u[0]}), 64'd0);
        tick();
        rst_ni = 1'b1;
        rsp_ready = 1'b1;
        tick();

        // Randomized traffic with random backpressure and occasional flush
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                tick();
            end else begin
                send(pick_addr(), 1'($urandom_range(0, 1)));
            end
        end
        drain();
        chk("queue_empty_a", 64'(q[0].size()), 64'd0);
        chk("queue_empty_b", 64'(q[1].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pma_check_pipe.md
Name: pma_check_pipe

Overview:
- Two-stage pipelined Physical Memory Attribute (PMA) lookup unit.
- Consumes the PMA region rules carried in the core configuration struct and classifies each physical address per cycle as cacheable, executable and non-idempotent.
- Sits between the MMU/PTW physical-address output and the LSU/frontend request paths, replacing per-consumer combinational region checks with a registered, backpressured stage.

Parameters:
- CVA6Cfg, default config_pkg::cva6_cfg_empty: core config; supplies NrCachedRegionRules, NrExecuteRegionRules, NrNonIdempotentRules and the corresponding base/length arrays (max 16 rules each).
- IdWidth, default 4: width of the opaque request tag carried alongside each address.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  drop all in-flight entries.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_addr_i  in  64  physical address.
- req_id_i  in  IdWidth  request tag.
- req_fetch_i  in  1  request is an instruction fetch.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer ready.
- rsp_addr_o  out  64  echoed address.
- rsp_id_o  out  IdWidth  echoed tag.
- rsp_cacheable_o  out  1  address hits a cached region.
- rsp_executable_o  out  1  address hits an execute region.
- rsp_nonidempotent_o  out  1  address hits a non-idempotent region.
- rsp_exec_fault_o  out  1  fetch request to a non-executable address.
- stat_exec_fault_o  out  32  exec-fault count (optional feature).
- stat_uncached_o  out  32  non-cacheable response count (optional feature).

Behaviour:
- Reset: both stage valids 0; all rsp_* outputs 0; stat_* 0; req_ready_o=1 after reset release.
- Stage 1 (S1) on accept registers:
  - addr, id, fetch.
  - Per rule and per class: ge = (addr >= base), lt = ({1'b0,addr} < 65-bit base+len). The 65-bit sum is mandatory so base+len never wraps.
  - Rules with index >= the class rule count register ge=lt=0.
- Stage 2 (S2):
  - hit[k] = ge[k] & lt[k]; class flag = OR over k.
  - Zero-rule classes: cacheable=0, nonidempotent=0, executable=1 (no execute rules means everything is executable).
  - exec_fault = fetch & ~executable.
  - S2 registers the flags; rsp_* are driven directly from S2 flops with no combinational path from req_* to rsp_*.
- Handshake:
  - Valid/ready per stage: stage_ready = ~stage_valid_q | next_ready.
  - req_ready_o = S1 ready; S2 next_ready = rsp_ready_i.
  - Latency 2 cycles from accept to rsp_valid_o without backpressure; throughput 1 request/cycle.
  - Once rsp_valid_o=1, rsp_* must hold stable until rsp_ready_i=1.
- Full/stall: with both stages valid and rsp_ready_i=0, req_ready_o=0 and no state changes.
- Simultaneous: S2 retiring while S1 advances while a new request is accepted is legal in one cycle (full throughput).
- Flush:
  - flush_i clears S1 and S2 valid at the next edge.
  - req_ready_o=0 while flush_i=1, so no request is accepted during flush.
  - rsp_valid_o may be high in the flush cycle; a handshake completing in that cycle is valid.
- Reset mid-operation: asynchronous clear of valids and counters; the datapath flops need no reset.

Optional Feature:
- Macro PMA_CHECK_STATS_EN.
- Defined:
  - Two 32-bit saturating counters incremented on each rsp handshake (rsp_valid_o & rsp_ready_i).
  - stat_exec_fault_o counts exec_fault responses.
  - stat_uncached_o counts responses with cacheable=0.
  - Both saturate at 0xFFFF_FFFF; flush does not clear them; reset does.
- Undefined: counters absent; stat_* tied to 0.

Test Plan:
- Config: cached 0x8000_0000/+0x4000_0000; nonidem 0x0/+0x8000_0000; exec 0x1_0000/+0x1_0000 and 0x8000_0000/+0x4000_0000. Send 0x8000_1000 fetch → 2 cycles later cacheable=1, executable=1, nonidem=0, fault=0.
- Send 0x1000_0000 fetch → cacheable=0, nonidem=1, executable=0, exec_fault=1; with STATS_EN both stat counters = 1.
- Boundary: 0xBFFF_FFFF → cacheable=1; 0xC000_0000 → cacheable=0. Rule base 0xFFFF_FFFF_FFFF_F000, len 0x1000: address 0xFFFF_FFFF_FFFF_FFFF → hit (no wrap).
- Back-to-back 8 requests with rsp_ready_i held 0 for 5 cycles → req_ready_o drops after 2 accepts; all 8 responses return in order with correct ids and stable data.
- flush_i with both stages valid → rsp_valid_o=0 next cycle; req_ready_o=0 during flush; no stale id emitted.
- Config with NrExecuteRegionRules=0 → every fetch executable=1, exec_fault=0; stat counter saturation preloaded via force at 0xFFFF_FFFE → stops at 0xFFFF_FFFF.
